// File: rtl/imem_loader_pkg.sv
// Shared state encoding and framing constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } load_state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

  // States in which the loader owns the byte stream.
  function automatic logic is_busy_state(input load_state_e s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian byte-to-word assembler: first byte of a word lands in bits [7:0].
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_ready,
  output logic [WORD_W-1:0] word
);

  localparam int SH_W = WORD_W - BYTE_W;

  logic [SH_W-1:0] shift_q, shift_d;
  logic [1:0]      cnt_q, cnt_d;

  // Only the first three bytes are stored; the fourth is taken straight from the input.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shift_d = {SH_W{1'b0}};
      cnt_d   = 2'd0;
    end else if (byte_valid) begin
      shift_d = {byte_in, shift_q[SH_W-1:BYTE_W]};
      cnt_d   = cnt_q + 2'd1;
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= {SH_W{1'b0}};
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_ready = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_in, shift_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte image into instruction memory and releases the core when complete.
// Optional trailing XOR checksum byte enabled by defining CHECKSUM_EN.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 2**(ADDR_W-2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_a,
  output logic [DATA_W-1:0] imem_wd,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IW = ADDR_W - 2;

  load_state_e       state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rel_q, rel_d;

  logic              start_s, rx_fire_s, data_fire_s, word_ready_s;
  logic [DATA_W-1:0] word_s;
  logic [15:0]       n_s;

  assign start_s     = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign rx_fire_s   = rx_valid && busy_q;
  assign data_fire_s = rx_fire_s && (state_q == DATA);
  assign n_s         = {rx_data, len_lo_q};

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_s),
    .byte_valid (data_fire_s),
    .byte_in    (rx_data),
    .word_ready (word_ready_s),
    .word       (word_s)
  );

`ifdef CHECKSUM_EN
  logic [7:0] chk_q, chk_d;

  // Running XOR over header and payload; the checksum byte itself is excluded.
  always_comb begin
    chk_d = chk_q;
    if (start_s) begin
      chk_d = 8'h00;
    end else if (rx_fire_s && (state_q != CHK)) begin
      chk_d = chk_q ^ rx_data;
    end else begin
      chk_d = chk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_q <= 8'h00;
    else        chk_q <= chk_d;
  end
`endif

  // Next-state, counters and write register.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    last_d   = last_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    a_d      = a_q;
    wd_d     = wd_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_s) begin
          state_d  = LEN_LO;
          len_lo_d = 8'h00;
          last_d   = {IW{1'b0}};
          idx_d    = {IW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      LEN_LO: begin
        if (rx_fire_s) begin
          len_lo_d = rx_data;
          state_d  = LEN_HI;
        end else begin
          state_d = LEN_LO;
        end
      end
      LEN_HI: begin
        if (rx_fire_s) begin
          if (n_s == 16'd0) begin
`ifdef CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else if ({16'd0, n_s} > 32'(MAX_WORDS)) begin
            state_d = ERR;
          end else begin
            last_d  = IW'(n_s - 16'd1);
            state_d = DATA;
          end
        end else begin
          state_d = LEN_HI;
        end
      end
      DATA: begin
        if (word_ready_s) begin
          we_d  = 1'b1;
          a_d   = {idx_q, 2'b00};
          wd_d  = word_s;
          idx_d = idx_q + IW'(1);
          if (idx_q == last_q) begin
`ifdef CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef CHECKSUM_EN
      CHK: begin
        if (rx_fire_s) begin
          state_d = (rx_data == chk_q) ? DONE : ERR;
        end else begin
          state_d = CHK;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are flop outputs.
  always_comb begin
    busy_d = is_busy_state(state_d);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
    rel_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_lo_q <= 8'h00;
      last_q   <= {IW{1'b0}};
      idx_q    <= {IW{1'b0}};
      we_q     <= 1'b0;
      a_q      <= {ADDR_W{1'b0}};
      wd_q     <= {DATA_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      a_q      <= a_d;
      wd_q     <= wd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rel_q    <= rel_d;
    end
  end

  assign rx_ready  = busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst_n = rel_q;
  assign imem_we   = we_q;
  assign imem_a    = a_q;
  assign imem_wd   = wd_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and randomized bench for imem_boot_loader; the expected writes come from a frame parser model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        imem_we, cpu_rst_n, busy, done, err;
  logic [9:0]  imem_a;
  logic [31:0] imem_wd;

  int n_assert = 0;
  int n_fail   = 0;
  int n_send;
  bit exp_err;
  logic [7:0]  frame_q[$];
  logic [41:0] exp_q[$];
  logic [41:0] got_q[$];

  imem_boot_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_a(imem_a), .imem_wd(imem_wd),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (imem_we) got_q.push_back({imem_a, imem_wd});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_chk();
`ifdef CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (frame_q[i]) x ^= frame_q[i];
    frame_q.push_back(x);
`endif
  endtask

  // Parse the frame the way a memory image consumer would see it.
  task automatic model();
    int n;
    exp_q.delete();
    n = int'(frame_q[0]) | (int'(frame_q[1]) << 8);
    if (n > 256) begin
      exp_err = 1'b1;
      n_send  = 2;
    end else begin
      for (int i = 0; i < n; i++)
        exp_q.push_back({10'(i * 4), frame_q[2+4*i+3], frame_q[2+4*i+2],
                         frame_q[2+4*i+1], frame_q[2+4*i]});
      n_send  = 2 + 4 * n;
      exp_err = 1'b0;
`ifdef CHECKSUM_EN
      begin
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n_send; i++) x ^= frame_q[i];
        exp_err = (frame_q[n_send] !== x);
        n_send++;
      end
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int c = 0;
    if (gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    chk("rx_ready_busy", {63'd0, rx_ready}, 64'd1);
    while (!rx_ready && c < 16) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic begin_load();
    got_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_check(input string tag, input int gap_mode, input bit mid_start);
    int c = 0;
    bit g;
    model();
    begin_load();
    chk({tag, "_busy_start"}, {60'd0, busy, done, err, cpu_rst_n}, 64'h8);
    for (int i = 0; i < n_send; i++) begin
      g = (gap_mode == 1) ? 1'b1 : ((gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (mid_start && i == 3) start = 1'b1;
      send_byte(frame_q[i], g);
      start = 1'b0;
    end
    while (!(done || err) && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, {63'd0, done}, {63'd0, !exp_err});
    chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
    chk({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n}, {63'd0, !exp_err});
    chk({tag, "_idle_flags"}, {62'd0, busy, rx_ready}, 64'd0);
    chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic basic_frame();
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    add_chk();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #2;
    chk("reset_outputs", 64'({rx_ready, imem_we, imem_a, imem_wd, cpu_rst_n, busy, done, err}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    basic_frame();
    run_check("two_words", 0, 1'b0);
    chk("two_words_first", 64'(got_q.size() > 0 ? got_q[0] : 42'h0), 64'({10'h000, 32'h00000013}));

    rx_valid = 1'b1; rx_data = 8'hAA;
    repeat (3) @(negedge clk);
    chk("done_ignores_rx", {61'd0, rx_ready, done, imem_we}, 64'h2);
    rx_valid = 1'b0;

    basic_frame();
    run_check("gapped", 1, 1'b0);

    basic_frame();
    run_check("start_while_busy", 0, 1'b1);

    frame_q = '{8'h00, 8'h01};
    for (int i = 0; i < 1024; i++) frame_q.push_back(8'($urandom));
    add_chk();
    run_check("max_len", 0, 1'b0);
    chk("max_last_addr", 64'(got_q.size() > 0 ? got_q[got_q.size()-1][41:32] : 10'h0), 64'h3FC);

    frame_q = '{8'h01, 8'h01};
    run_check("too_long", 0, 1'b0);

    frame_q = '{8'h00, 8'h00};
    add_chk();
    run_check("zero_len", 0, 1'b0);

`ifdef CHECKSUM_EN
    frame_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    run_check("chk_good", 0, 1'b0);
    frame_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_check("chk_bad", 0, 1'b0);
`endif

    for (int t = 0; t < 5; t++) begin
      int n = $urandom_range(1, 12);
      frame_q = '{8'(n), 8'h00};
      for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
      add_chk();
`ifdef CHECKSUM_EN
      if (t == 3) frame_q[frame_q.size()-1] ^= 8'h5A;
`endif
      run_check("random", 2, t == 1);
    end

    basic_frame();
    model();
    begin_load();
    for (int i = 0; i < 7; i++) send_byte(frame_q[i], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 64'({rx_ready, imem_we, imem_a, imem_wd, cpu_rst_n, busy, done, err}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_check("after_reset", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
